// File: rtl/decode_issue_queue.sv
// Decode issue queue: circular instruction buffer feeding the two decode slots.
// Define DECODE_DUAL_ISSUE_EN for dual issue with pairing rules; default build issues one per cycle.
module decode_issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [1:0]  in_en,
  input  logic [63:0] in_instr,
  input  logic [63:0] in_pcplus4,
  input  logic [1:0]  in_exc,
  input  logic [1:0]  in_pred,
  output logic        in_ready,
  output logic [1:0]  out_valid,
  output logic [63:0] out_instr,
  output logic [63:0] out_pcplus4,
  output logic [1:0]  out_exc,
  output logic [1:0]  out_pred,
  input  logic        out_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        exc;
    logic        pred;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;

  entry_t [1:0]  w_in;
  entry_t        w_e0, w_e1;
  logic [CW-1:0] w_npush, w_npop;
  logic          w_ge1, w_ge2, w_br0;

  function automatic logic f_br(input logic [5:0] op, input logic [5:0] fn);
    return (op inside {[6'h01:6'h07]}) || (op == 6'h00 && (fn == 6'h08 || fn == 6'h09));
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_lane
    assign w_in[k] = {in_instr[32*k +: 32], in_pcplus4[32*k +: 32], in_exc[k], in_pred[k]};
  end

  // head+1 wraps for free because the pointer is exactly log2(DEPTH) bits
  assign w_e0     = r_mem[r_head];
  assign w_e1     = r_mem[r_head + PW'(1)];
  assign w_ge1    = (r_count != '0);
  assign w_ge2    = (r_count >= CW'(2));
  assign w_br0    = f_br(w_e0.instr[31:26], w_e0.instr[5:0]);
  assign in_ready = (r_count <= CW'(DEPTH - 2));

`ifdef DECODE_DUAL_ISSUE_EN
  function automatic logic f_ser(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h10) || (op == 6'h00 && (fn == 6'h0C || fn == 6'h0D));
  endfunction

  function automatic logic f_md(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && (fn[5:3] == 3'b011 || fn[5:2] == 4'b0100);
  endfunction

  function automatic logic [4:0] f_dest(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rd);
    logic [4:0] d;
    d = 5'd0;
    if (op == 6'h00)                                d = rd;
    else if (op == 6'h03)                           d = 5'd31;
    else if (op[5:3] == 3'b001 || op[5:3] == 3'b100) d = rt;
    else if (op == 6'h01 && rt[4])                  d = 5'd31;
    return d;
  endfunction

  function automatic logic f_rt_src(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op[5:3] == 3'b101);
  endfunction

  logic [5:0] w_op0, w_op1, w_fn0, w_fn1;
  logic [4:0] w_dest0, w_rs1, w_rt1;
  logic       w_raw, w_exc, w_pair_ok;

  assign w_op0   = w_e0.instr[31:26];
  assign w_fn0   = w_e0.instr[5:0];
  assign w_op1   = w_e1.instr[31:26];
  assign w_fn1   = w_e1.instr[5:0];
  assign w_rs1   = w_e1.instr[25:21];
  assign w_rt1   = w_e1.instr[20:16];
  assign w_dest0 = f_dest(w_op0, w_e0.instr[20:16], w_e0.instr[15:11]);
  assign w_raw   = (w_dest0 != 5'd0) &&
                   (w_dest0 == w_rs1 || (f_rt_src(w_op1) && w_dest0 == w_rt1));
  assign w_exc   = w_e0.exc | w_e1.exc;

  // A branch at head only needs its delay slot to be independent and exception-free
  always_comb begin
    w_pair_ok = 1'b1;
    if (w_br0)
      w_pair_ok = !(w_raw || w_exc);
    else if (f_br(w_op1, w_fn1) || (w_e0.instr[31] && w_e1.instr[31]) ||
             f_ser(w_op0, w_fn0) || f_ser(w_op1, w_fn1) ||
             (f_md(w_op0, w_fn0) && f_md(w_op1, w_fn1)) || w_raw || w_exc)
      w_pair_ok = 1'b0;
  end

  assign out_valid[1] = w_ge2 && w_pair_ok;
  assign out_valid[0] = w_br0 ? (w_ge2 && w_pair_ok) : w_ge1;
`else
  assign out_valid[1] = 1'b0;
  assign out_valid[0] = w_ge1 && !(w_br0 && !w_ge2);
`endif

  assign w_npush = in_ready  ? (CW'(in_en[0]) + CW'(in_en[1]))         : '0;
  assign w_npop  = out_ready ? (CW'(out_valid[0]) + CW'(out_valid[1])) : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (in_ready && in_en[0]) r_mem[r_tail]          <= w_in[0];
      if (in_ready && in_en[1]) r_mem[r_tail + PW'(1)] <= w_in[1];
      r_tail  <= r_tail + PW'(w_npush);
      r_head  <= r_head + PW'(w_npop);
      r_count <= r_count + w_npush - w_npop;
    end
  end

  assign out_instr   = {w_e1.instr, w_e0.instr};
  assign out_pcplus4 = {w_e1.pc4, w_e0.pc4};
  assign out_exc     = {w_e1.exc, w_e0.exc};
  assign out_pred    = {w_e1.pred, w_e0.pred};
endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: queue-based reference model checked every cycle plus directed literals.
module tb_decode_issue_queue;
  localparam int DEPTH = 8;
`ifdef DECODE_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic        clk, resetn, flush, in_ready, out_ready;
  logic [1:0]  in_en, in_exc, in_pred, out_valid, out_exc, out_pred;
  logic [63:0] in_instr, in_pcplus4, out_instr, out_pcplus4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        exc;
    logic        pred;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pcn = 32'h1000;

  decode_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_en(in_en), .in_instr(in_instr),
    .in_pcplus4(in_pcplus4), .in_exc(in_exc), .in_pred(in_pred), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pcplus4(out_pcplus4),
    .out_exc(out_exc), .out_pred(out_pred), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // ---- instruction classes straight from the ISA description ----
  function automatic logic m_br(input logic [31:0] w);
    logic [5:0] op, fn;
    op = w[31:26]; fn = w[5:0];
    return (op >= 6'h01 && op <= 6'h07) || (op == 6'h00 && (fn == 6'h08 || fn == 6'h09));
  endfunction

  function automatic logic m_ser(input logic [31:0] w);
    return (w[31:26] == 6'h10) || (w[31:26] == 6'h00 && (w[5:0] == 6'h0C || w[5:0] == 6'h0D));
  endfunction

  function automatic logic m_md(input logic [31:0] w);
    return (w[31:26] == 6'h00) && ((w[5:0] >= 6'h18 && w[5:0] <= 6'h1F) ||
                                  (w[5:0] >= 6'h10 && w[5:0] <= 6'h13));
  endfunction

  function automatic int m_dest(input logic [31:0] w);
    case (w[31:26]) inside
      6'h00:                     return int'(w[15:11]);
      6'h03:                     return 31;
      [6'h08:6'h0F], [6'h20:6'h27]: return int'(w[20:16]);
      6'h01:                     return w[20] ? 31 : 0;
      default:                   return 0;
    endcase
  endfunction

  function automatic logic m_reads(input logic [31:0] w, input int r);
    logic [5:0] op;
    op = w[31:26];
    if (r == int'(w[25:21])) return 1'b1;
    if ((op == 6'h00 || op == 6'h04 || op == 6'h05 || (op >= 6'h28 && op <= 6'h2F)) &&
        r == int'(w[20:16])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_valid();
    int   n = q.size();
    logic v0, v1, ok, raw, ex;
    v0 = 1'b0; v1 = 1'b0;
    if (n >= 1) v0 = !(m_br(q[0].instr) && n < 2);
    if (DUAL && n >= 2) begin
      raw = (m_dest(q[0].instr) != 0) && m_reads(q[1].instr, m_dest(q[0].instr));
      ex  = q[0].exc || q[1].exc;
      if (m_br(q[0].instr)) ok = !raw && !ex;
      else ok = !(m_br(q[1].instr) || (q[0].instr[31] && q[1].instr[31]) ||
                  m_ser(q[0].instr) || m_ser(q[1].instr) ||
                  (m_md(q[0].instr) && m_md(q[1].instr)) || raw || ex);
      v1 = ok;
      if (m_br(q[0].instr)) v0 = ok;
    end
    return {v1, v0};
  endfunction

  // ---- reference model state update ----
  always @(posedge clk or negedge resetn) begin
    logic [1:0] v;
    int         n;
    if (!resetn) q.delete();
    else begin
      v = m_valid();
      n = q.size();
      if (flush) q.delete();
      else begin
        if (out_ready) for (int p = 0; p < int'(v[0]) + int'(v[1]); p++) void'(q.pop_front());
        if (DEPTH - n >= 2) begin
          if (in_en[0]) q.push_back('{in_instr[31:0], in_pcplus4[31:0], in_exc[0], in_pred[0]});
          if (in_en[1]) q.push_back('{in_instr[63:32], in_pcplus4[63:32], in_exc[1], in_pred[1]});
        end
      end
    end
  end

  // ---- per-cycle compare ----
  always @(negedge clk) begin
    logic [1:0] ev;
    ev = m_valid();
    chk("in_ready", {63'd0, in_ready}, {63'd0, (DEPTH - q.size()) >= 2});
    chk("out_valid", {62'd0, out_valid}, {62'd0, ev});
    for (int s = 0; s < 2; s++) begin
      if (ev[s]) begin
        chk("slot_instr", {32'd0, out_instr[32*s +: 32]}, {32'd0, q[s].instr});
        chk("slot_pc4", {32'd0, out_pcplus4[32*s +: 32]}, {32'd0, q[s].pc4});
        chk("slot_exc", {63'd0, out_exc[s]}, {63'd0, q[s].exc});
        chk("slot_pred", {63'd0, out_pred[s]}, {63'd0, q[s].pred});
      end
    end
  end

  task automatic cyc(input logic [1:0] en, input logic [31:0] i0, input logic [31:0] i1,
                     input logic [1:0] ex, input logic ordy, input logic fl);
    in_en = en; in_instr = {i1, i0}; in_pcplus4 = {pcn + 32'd8, pcn + 32'd4};
    in_exc = ex; in_pred = pcn[4:3]; out_ready = ordy; flush = fl;
    @(negedge clk); #1;
    pcn = pcn + 32'd8;
    in_en = 2'b00; flush = 1'b0;
  endtask

  task automatic idle(input logic ordy);
    cyc(2'b00, 32'd0, 32'd0, 2'b00, ordy, 1'b0);
  endtask

  logic [31:0] ta [13];
  logic [31:0] tb [13];
  logic [1:0]  tex [13];
  logic [1:0]  tdu [13];
  logic [31:0] p5;

  initial begin
    resetn = 1'b0; flush = 1'b0; in_en = 2'b00; in_instr = '0; in_pcplus4 = '0;
    in_exc = 2'b00; in_pred = 2'b00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", {62'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_instr", out_instr, 64'd0);
    resetn = 1'b1;

    // T1: async reset while holding two entries
    cyc(2'b11, enc_r(5'd1, 5'd2, 5'd3, 6'h21), enc_r(5'd4, 5'd5, 5'd6, 6'h21), 2'b00, 1'b0, 1'b0);
    chk("t1_pre_valid", {62'd0, out_valid}, DUAL ? 64'd3 : 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t1_valid", {62'd0, out_valid}, 64'd0);
    chk("t1_ready", {63'd0, in_ready}, 64'd1);
    chk("t1_instr", out_instr, 64'd0);
    @(negedge clk); #1 resetn = 1'b1;

    // T2: independent pair
    cyc(2'b11, enc_r(5'd1, 5'd2, 5'd3, 6'h21), enc_r(5'd4, 5'd5, 5'd6, 6'h21), 2'b00, 1'b1, 1'b0);
    chk("t2_v0", {62'd0, out_valid}, DUAL ? 64'd3 : 64'd1);
    idle(1'b1);
    chk("t2_v1", {62'd0, out_valid}, DUAL ? 64'd0 : 64'd1);
    idle(1'b1);
    chk("t2_v2", {62'd0, out_valid}, 64'd0);

    // T3: RAW keeps the subu for the next cycle
    cyc(2'b11, enc_r(5'd1, 5'd2, 5'd3, 6'h21), enc_r(5'd3, 5'd4, 5'd5, 6'h23), 2'b00, 1'b1, 1'b0);
    chk("t3_v0", {62'd0, out_valid}, 64'd1);
    idle(1'b1);
    chk("t3_v1", {62'd0, out_valid}, 64'd1);
    chk("t3_subu", {32'd0, out_instr[31:0]}, {32'd0, enc_r(5'd3, 5'd4, 5'd5, 6'h23)});
    idle(1'b1);
    chk("t3_v2", {62'd0, out_valid}, 64'd0);

    // T4: branch waits for its delay slot
    cyc(2'b01, enc_i(6'h04, 5'd1, 5'd2, 16'd8), 32'd0, 2'b00, 1'b1, 1'b0);
    chk("t4_hold0", {62'd0, out_valid}, 64'd0);
    for (int k = 1; k < 4; k++) begin
      idle(1'b1);
      chk($sformatf("t4_hold%0d", k), {62'd0, out_valid}, 64'd0);
    end
    cyc(2'b01, 32'd0, 32'd0, 2'b00, 1'b1, 1'b0);
    chk("t4_go", {62'd0, out_valid}, DUAL ? 64'd3 : 64'd1);
    chk("t4_beq", {32'd0, out_instr[31:0]}, {32'd0, enc_i(6'h04, 5'd1, 5'd2, 16'd8)});
    idle(1'b1);
    chk("t4_slot", {62'd0, out_valid}, DUAL ? 64'd0 : 64'd1);
    idle(1'b1);
    chk("t4_empty", {62'd0, out_valid}, 64'd0);

    // T5: fill to full starting at head=6, then drain across the wrap
    p5 = pcn;
    for (int k = 0; k < 4; k++) begin
      cyc(2'b11, enc_r(5'd1, 5'd2, 5'(10 + 2*k), 6'h21), enc_r(5'd1, 5'd2, 5'(11 + 2*k), 6'h21),
          2'b00, 1'b0, 1'b0);
      chk($sformatf("t5_ready%0d", k), {63'd0, in_ready}, (k < 3) ? 64'd1 : 64'd0);
    end
    chk("t5_head_pc", {32'd0, out_pcplus4[31:0]}, {32'd0, p5 + 32'd4});
    chk("t5_head_instr", {32'd0, out_instr[31:0]}, {32'd0, enc_r(5'd1, 5'd2, 5'd10, 6'h21)});
    // push while full and popping: the pop must not make room this cycle
    cyc(2'b11, enc_r(5'd1, 5'd2, 5'd20, 6'h21), enc_r(5'd1, 5'd2, 5'd21, 6'h21), 2'b00, 1'b1, 1'b0);
    chk("t5_ready_pop", {63'd0, in_ready}, DUAL ? 64'd1 : 64'd0);
    chk("t5_next", {32'd0, out_instr[31:0]},
        {32'd0, enc_r(5'd1, 5'd2, DUAL ? 5'd12 : 5'd11, 6'h21)});
    repeat (9) idle(1'b1);
    chk("t5_drained", {62'd0, out_valid}, 64'd0);
    chk("t5_ready_end", {63'd0, in_ready}, 64'd1);

    // T6: flush beats same-cycle push and pop
    cyc(2'b11, enc_r(5'd1, 5'd2, 5'd3, 6'h21), enc_r(5'd1, 5'd2, 5'd4, 6'h21), 2'b00, 1'b0, 1'b0);
    cyc(2'b01, enc_r(5'd1, 5'd2, 5'd5, 6'h21), 32'd0, 2'b00, 1'b0, 1'b0);
    chk("t6_pre_ready", {63'd0, in_ready}, 64'd1);
    cyc(2'b11, enc_r(5'd1, 5'd2, 5'd7, 6'h21), enc_r(5'd1, 5'd2, 5'd8, 6'h21), 2'b00, 1'b1, 1'b1);
    chk("t6_valid", {62'd0, out_valid}, 64'd0);
    chk("t6_ready", {63'd0, in_ready}, 64'd1);
    idle(1'b1);
    chk("t6_still_empty", {62'd0, out_valid}, 64'd0);
    cyc(2'b11, enc_r(5'd1, 5'd2, 5'd9, 6'h21), enc_r(5'd4, 5'd5, 5'd6, 6'h21), 2'b00, 1'b1, 1'b0);
    chk("t6_refill", {32'd0, out_instr[31:0]}, {32'd0, enc_r(5'd1, 5'd2, 5'd9, 6'h21)});
    repeat (2) idle(1'b1);

    // T7: pairing corner cases, each loaded into an empty queue then flushed
    ta  = '{enc_i(6'h23, 5'd1, 5'd8, 16'd0), enc_i(6'h23, 5'd1, 5'd8, 16'd0),
            enc_i(6'h23, 5'd1, 5'd8, 16'd0), enc_r(5'd1, 5'd2, 5'd0, 6'h18),
            enc_r(5'd0, 5'd0, 5'd5, 6'h12), enc_r(5'd0, 5'd0, 5'd0, 6'h0C),
            enc_r(5'd1, 5'd2, 5'd3, 6'h21), enc_r(5'd1, 5'd2, 5'd3, 6'h21),
            {6'h03, 26'h10},                  enc_i(6'h04, 5'd1, 5'd2, 16'd8),
            enc_r(5'd1, 5'd2, 5'd5, 6'h21), enc_r(5'd1, 5'd2, 5'd0, 6'h21),
            enc_i(6'h04, 5'd1, 5'd2, 16'd8)};
    tb  = '{enc_i(6'h2B, 5'd2, 5'd9, 16'd0), enc_r(5'd8, 5'd1, 5'd10, 6'h21),
            enc_r(5'd3, 5'd4, 5'd10, 6'h21), enc_r(5'd3, 5'd4, 5'd0, 6'h1A),
            enc_r(5'd1, 5'd2, 5'd6, 6'h21), 32'd0,
            enc_r(5'd4, 5'd5, 5'd6, 6'h21), enc_i(6'h04, 5'd3, 5'd4, 16'd8),
            enc_r(5'd31, 5'd0, 5'd2, 6'h21), enc_r(5'd0, 5'd0, 5'd0, 6'h0C),
            enc_i(6'h2B, 5'd9, 5'd5, 16'd0), enc_r(5'd0, 5'd0, 5'd3, 6'h21),
            32'd0};
    tex = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10,
            2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    tdu = '{2'b01, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01,
            2'b01, 2'b00, 2'b11, 2'b01, 2'b11, 2'b00};
    for (int r = 0; r < 13; r++) begin
      cyc(2'b11, ta[r], tb[r], tex[r], 1'b0, 1'b0);
      chk($sformatf("t7_row%0d", r), {62'd0, out_valid}, {62'd0, DUAL ? tdu[r] : 2'b01});
      cyc(2'b00, 32'd0, 32'd0, 2'b00, 1'b0, 1'b1);
    end
    idle(1'b1);
    chk("t7_end", {62'd0, out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
